// File: rtl/return_address_stack_ckpt.sv
// Checkpoint-repairing return address stack: combinational prediction, synchronous push/pop/coroutine.
// Updates land on the next rising edge; i_stall freezes state, a misprediction restore overrides the stall.
module return_address_stack_ckpt #(
  parameter int RAS_DEPTH    = 8,
  parameter int ADDR_WIDTH   = 32,
  parameter int RAS_PTR_BITS = $clog2(RAS_DEPTH)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_stall,
  input  logic                    i_push,
  input  logic                    i_pop,
  input  logic                    i_prediction_allowed,
  input  logic [ADDR_WIDTH-1:0]   i_link_address,
  input  logic                    i_misprediction,
  input  logic [RAS_PTR_BITS-1:0] i_restore_tos,
  input  logic [RAS_PTR_BITS:0]   i_restore_valid_count,
  input  logic [ADDR_WIDTH-1:0]   i_restore_top_data,
  input  logic                    i_pop_after_restore,
  output logic                    o_ras_valid,
  output logic [ADDR_WIDTH-1:0]   o_ras_target,
  output logic [RAS_PTR_BITS-1:0] o_checkpoint_tos,
  output logic [RAS_PTR_BITS:0]   o_checkpoint_valid_count,
  output logic [ADDR_WIDTH-1:0]   o_checkpoint_top_data,
  output logic                    o_overflow,
  output logic                    o_underflow
);

  localparam logic [RAS_PTR_BITS:0] FULL_CNT = RAS_DEPTH[RAS_PTR_BITS:0];

  logic [ADDR_WIDTH-1:0]   entry_q [RAS_DEPTH];
  logic [RAS_PTR_BITS-1:0] tos_q, tos_d;
  logic [RAS_PTR_BITS:0]   cnt_q, cnt_d;
  logic                    wr_en;
  logic [RAS_PTR_BITS-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0]   wr_dat;
  logic                    not_empty, pop_ok, normal_op;
  logic [ADDR_WIDTH-1:0]   top_dat;

  assign not_empty = (cnt_q != '0);
  assign pop_ok    = i_pop && i_prediction_allowed && not_empty;
  assign normal_op = !i_stall && !i_misprediction;
  assign top_dat   = not_empty ? entry_q[tos_q] : '0;

  // Single write port: restore beats coroutine beats push.
  always_comb begin
    tos_d   = tos_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_addr = tos_q;
    wr_dat  = i_link_address;
    if (i_misprediction) begin
      wr_en   = 1'b1;
      wr_addr = i_restore_tos;
      wr_dat  = i_restore_top_data;
      if (i_pop_after_restore && (i_restore_valid_count != '0)) begin
        tos_d = i_restore_tos - 1'b1;
        cnt_d = i_restore_valid_count - 1'b1;
      end else begin
        tos_d = i_restore_tos;
        cnt_d = i_restore_valid_count;
      end
    end else if (!i_stall) begin
      if (i_push && pop_ok) begin
        wr_en = 1'b1;
      end else if (i_push) begin
        wr_en   = 1'b1;
        wr_addr = tos_q + 1'b1;
        tos_d   = tos_q + 1'b1;
        if (cnt_q != FULL_CNT) cnt_d = cnt_q + 1'b1;
      end else if (pop_ok) begin
        tos_d = tos_q - 1'b1;
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tos_q <= '0;
      cnt_q <= '0;
    end else begin
      tos_q <= tos_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage is deliberately unreset; reads are masked while the stack is empty.
  always_ff @(posedge i_clk) begin
    if (wr_en) entry_q[wr_addr] <= wr_dat;
  end

  assign o_ras_valid              = pop_ok && !i_misprediction;
  assign o_ras_target             = top_dat;
  assign o_checkpoint_tos         = tos_q;
  assign o_checkpoint_valid_count = cnt_q;
  assign o_checkpoint_top_data    = top_dat;
  assign o_overflow  = normal_op && i_push && !pop_ok && (cnt_q == FULL_CNT);
  assign o_underflow = i_rst_n && normal_op && i_pop && i_prediction_allowed && !not_empty;

  restore_count_legal: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    i_misprediction |-> (i_restore_valid_count <= FULL_CNT));

endmodule

// File: doc/return_address_stack_ckpt.md
# return_address_stack_ckpt

Parametrised, checkpoint-repairing return address stack for the IF-stage branch predictor. It provides combinational return-target prediction and synchronous push, pop and coroutine updates. Unlike the previous RAS generation, its checkpoint includes the top-of-stack entry data, so a misprediction repairs an entry that a wrong-path push or coroutine overwrote, not just the pointers. Depth and address width are configurable, and overflow and underflow events are reported to performance counters.

## Interface
- RAS_DEPTH, 8: number of entries; power of two, ≥2.
- ADDR_WIDTH, riscv_pkg::XLEN: width of stored return addresses.
- RAS_PTR_BITS, $clog2(RAS_DEPTH): pointer width; derived, do not override.

- i_clk  in  1  single clock; all state updates on its rising edge.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_stall  in  1  holds all state when high; restore is not stalled.
- i_push  in  1  call detected (rd ∈ {x1,x5}); already qualified by instruction validity.
- i_pop  in  1  return detected (rs1 ∈ {x1,x5}, rd = x0).
- i_prediction_allowed  in  1  gates every pop, including the pop half of a coroutine.
- i_link_address  in  ADDR_WIDTH  address to push.
- i_misprediction  in  1  restore request from EX.
- i_restore_tos  in  RAS_PTR_BITS  checkpointed TOS.
- i_restore_valid_count  in  RAS_PTR_BITS+1  checkpointed count.
- i_restore_top_data  in  ADDR_WIDTH  checkpointed content of entry[i_restore_tos].
- i_pop_after_restore  in  1  pop once after restoring.
- o_ras_valid  out  1  prediction available.
- o_ras_target  out  ADDR_WIDTH  predicted return address.
- o_checkpoint_tos  out  RAS_PTR_BITS  current TOS.
- o_checkpoint_valid_count  out  RAS_PTR_BITS+1  current count.
- o_checkpoint_top_data  out  ADDR_WIDTH  current entry[tos].
- o_overflow  out  1  push performed while full; overwrites the oldest entry.
- o_underflow  out  1  pop requested and allowed while empty.

## Operation
- State: entry array (not reset), tos, valid_count. Reset sets tos=0 and valid_count=0.
- pop_ok = i_pop && i_prediction_allowed && valid_count≠0.
- Operations, evaluated only when !i_stall && !i_misprediction:
  - Coroutine (i_push && pop_ok): write entry[tos] ← link; tos and count unchanged.
  - Push (i_push && !pop_ok):
    - write entry[tos+1] ← link; tos ← tos+1 (wraps modulo RAS_DEPTH).
    - count ← count+1, saturating at RAS_DEPTH.
    - o_overflow = 1 if count was already RAS_DEPTH.
  - Pop (pop_ok && !i_push): tos ← tos−1 (wraps); count ← count−1. No write.
  - A pop that is requested while empty (or not allowed) is a no-op. If it was allowed, o_underflow = 1.
- Restore (i_misprediction; overrides stall and every normal operation):
  - write entry[i_restore_tos] ← i_restore_top_data.
  - If i_pop_after_restore && i_restore_valid_count≠0: tos ← i_restore_tos−1 and count ← i_restore_valid_count−1.
  - Otherwise: tos ← i_restore_tos and count ← i_restore_valid_count.
  - i_restore_valid_count > RAS_DEPTH is illegal; verification flags it as an assertion.
- At most one array write per cycle. Write address priority: restore, then coroutine (tos), then push (tos+1).
- Prediction is combinational from current state:
  - o_ras_valid = i_pop && i_prediction_allowed && valid_count≠0 && !i_misprediction.
  - o_ras_target = entry[tos] when valid_count≠0, else 0.
- Checkpoint outputs reflect pre-update state in the cycle the instruction is predicted.
- o_checkpoint_top_data = entry[tos] when count≠0, else 0.
- o_overflow and o_underflow are combinational, single-cycle, and 0 during stall, restore and reset.

## Timing
- Reset values: o_ras_valid=0, o_ras_target=0, o_checkpoint_tos=0, o_checkpoint_valid_count=0, o_checkpoint_top_data=0, o_overflow=0, o_underflow=0.
- Assertion of i_rst_n low takes effect immediately (asynchronous). Operations in flight are discarded.
- Zero-cycle prediction latency.
- A push or pop in cycle N is visible on outputs in cycle N+1.
- Back-to-back push and pop in consecutive cycles: the pop in N+1 returns the address pushed in N.
- Restore in cycle N: outputs in N+1 reflect the restored state and the repaired entry.
- A stalled cycle changes nothing; outputs are stable apart from combinational input dependence.

## Test plan
- Reset, push 0x100, 0x200, 0x300 in three cycles, then hold i_pop=1 for three cycles:
  - targets 0x300, 0x200, 0x100 with o_ras_valid=1.
  - fourth pop: o_ras_valid=0, o_underflow=1, count stays 0.
- Overflow at RAS_DEPTH=8: push 9 addresses A1..A9.
  - ninth push: o_overflow=1, count stays 8.
  - eight pops then return A9..A2.
  - ninth pop: o_ras_valid=0.
- Checkpoint repair:
  - push 0x400, capture checkpoint (tos=1, count=1, top=0x400).
  - coroutine with link 0x999, then push 0x500.
  - restore the captured checkpoint: next cycle target=0x400, count=1.
- pop_after_restore: restore with tos=2, count=2, i_pop_after_restore=1 → next cycle tos=1, count=1, target = entry[1].
- Simultaneous events:
  - stall plus push: no change.
  - misprediction plus push plus stall: restore wins and the push is lost.
  - i_prediction_allowed=0 with i_pop: no pop, o_ras_valid=0.
- Asynchronous reset mid-sequence with count=5: drop i_rst_n between clock edges → all outputs 0 immediately, with no clock edge.
